// File: rtl/board_io_ctrl.sv
// Board I/O peripheral: synchronised, debounced buttons with sticky events and a level IRQ,
// synchronised switches and an LED register. Define BOARD_IO_RELEASE_EVT_EN to flag releases too.
module board_io_ctrl #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned N_SW            = 8,
  parameter int unsigned N_LED           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DATA_W          = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_BTN-1:0]  i_btn,
  input  logic [N_SW-1:0]   i_sw,
  output logic [N_LED-1:0]  o_led,
  input  logic [1:0]        i_addr,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_irq
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]  btn_meta_q, btn_sync_q;
  logic [N_SW-1:0]   sw_meta_q, sw_sync_q;
  logic [N_BTN-1:0]  stable_q, stable_d;
  logic [CntW-1:0]   cnt_q [N_BTN];
  logic [CntW-1:0]   cnt_d [N_BTN];
  logic [N_BTN-1:0]  evt_q, evt_d, evt_set, evt_clr;
  logic [N_LED-1:0]  led_q, led_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, rd_mux;
  logic              rd_valid_q, rd_valid_d;

  // Debounce: a new level is accepted on the DEBOUNCE_CYCLES-th consecutive differing edge.
  always_comb begin
    stable_d = stable_q;
    evt_set  = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (btn_sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = btn_sync_q[i];
`ifdef BOARD_IO_RELEASE_EVT_EN
          evt_set[i]  = 1'b1;
`else
          evt_set[i]  = btn_sync_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    evt_clr = (i_wr_en && i_addr == 2'd2) ? i_wr_data[N_BTN-1:0] : '0;
    // A press landing on the same edge as a clear keeps the bit set.
    evt_d   = (evt_q & ~evt_clr) | evt_set;
    led_d   = (i_wr_en && i_addr == 2'd0) ? i_wr_data[N_LED-1:0] : led_q;

    rd_mux = '0;
    case (i_addr)
      2'd0:    rd_mux[N_LED-1:0] = led_q;
      2'd1:    rd_mux[N_BTN-1:0] = stable_q;
      2'd2:    rd_mux[N_BTN-1:0] = evt_q;
      default: rd_mux[N_SW-1:0]  = sw_sync_q;
    endcase
    rd_data_d  = i_rd_en ? rd_mux : rd_data_q;
    rd_valid_d = i_rd_en;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      stable_q   <= '0;
      cnt_q      <= '{default: '0};
      evt_q      <= '0;
      led_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      btn_meta_q <= i_btn;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= i_sw;
      sw_sync_q  <= sw_meta_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
      led_q      <= led_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_led      = led_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_irq      = |evt_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl (DEBOUNCE_CYCLES=4): directed stimulus, a behavioural model checked
// every cycle, plus hand-computed literal expectations.
module tb_board_io_ctrl;

  localparam int unsigned D = 4;
`ifdef BOARD_IO_RELEASE_EVT_EN
  localparam bit RelEvt = 1'b1;
`else
  localparam bit RelEvt = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [4:0] i_btn;
  logic [7:0] i_sw;
  logic [7:0] o_led;
  logic [1:0] i_addr;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       i_rd_en;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       o_irq;

  board_io_ctrl #(
    .N_BTN(5), .N_SW(8), .N_LED(8), .DEBOUNCE_CYCLES(D), .DATA_W(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn), .i_sw(i_sw), .o_led(o_led),
    .i_addr(i_addr), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .i_rd_en(i_rd_en),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs reach the debouncer two edges late; a button level is accepted
  // once it has differed from the accepted level on D consecutive edges.
  bit         m_live = 1'b0;
  logic [4:0] m_bmeta, m_bsync, m_stable, m_evt, m_set, m_clr;
  logic [7:0] m_smeta, m_ssync, m_led, m_rd_data;
  logic       m_rd_valid;
  int         m_run [5];

  function automatic logic [7:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return m_led;
      2'd1:    return {3'b0, m_stable};
      2'd2:    return {3'b0, m_evt};
      default: return m_ssync;
    endcase
  endfunction

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_live = 1'b1;
      m_bmeta = '0; m_bsync = '0; m_stable = '0; m_evt = '0;
      m_smeta = '0; m_ssync = '0; m_led = '0; m_rd_data = '0; m_rd_valid = 1'b0;
      for (int b = 0; b < 5; b++) m_run[b] = 0;
    end else begin
      m_rd_valid = i_rd_en;
      if (i_rd_en) m_rd_data = m_reg(i_addr);
      m_set = '0;
      for (int b = 0; b < 5; b++) begin
        if (m_bsync[b] != m_stable[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == D) begin
            m_stable[b] = m_bsync[b];
            m_run[b] = 0;
            if (m_bsync[b] || RelEvt) m_set[b] = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_clr = (i_wr_en && i_addr == 2'd2) ? i_wr_data[4:0] : 5'd0;
      m_evt = (m_evt & ~m_clr) | m_set;
      if (i_wr_en && i_addr == 2'd0) m_led = i_wr_data;
      m_bsync = m_bmeta; m_bmeta = i_btn;
      m_ssync = m_smeta; m_smeta = i_sw;
    end
  end

  always @(negedge i_clk) begin
    if (m_live) begin
      chk("led_model", o_led, m_led);
      chk("irq_model", {7'b0, o_irq}, {7'b0, |m_evt});
      chk("rd_valid_model", {7'b0, o_rd_valid}, {7'b0, m_rd_valid});
      chk("rd_data_model", o_rd_data, m_rd_data);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    i_addr = a; i_wr_data = d; i_wr_en = 1'b1;
    step(1);
    i_wr_en = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [1:0] a, input logic [7:0] exp);
    i_addr = a; i_rd_en = 1'b1;
    step(1);
    i_rd_en = 1'b0;
    chk({name, "_valid"}, {7'b0, o_rd_valid}, 8'h01);
    chk(name, o_rd_data, exp);
  endtask

  initial begin
    i_rst_n = 1'b0; i_btn = 5'h1F; i_sw = 8'hFF;
    i_addr = '0; i_wr_en = 1'b0; i_wr_data = '0; i_rd_en = 1'b0;
    step(3);
    chk("rst_led", o_led, 8'h00);
    chk("rst_irq", {7'b0, o_irq}, 8'h00);
    chk("rst_rd_valid", {7'b0, o_rd_valid}, 8'h00);

    // Buttons held through reset are re-debounced: state at edge 2+D after release.
    i_rst_n = 1'b1;
    do_read("post_rst_state", 2'd1, 8'h00);
    do_read("post_rst_evt", 2'd2, 8'h00);
    step(3);
    chk("held_irq_early", {7'b0, o_irq}, 8'h00);
    step(1);
    chk("held_irq_on_time", {7'b0, o_irq}, 8'h01);
    do_read("held_state", 2'd1, 8'h1F);

    i_btn = 5'h00;
    do_write(2'd2, 8'h1F);
    chk("clear_all_irq", {7'b0, o_irq}, 8'h00);
    step(8);
    chk("release_all_irq", {7'b0, o_irq}, {7'b0, RelEvt});
    do_write(2'd2, 8'h1F);

    // Clean press on button 1.
    i_btn = 5'h02;
    step(5);
    chk("press_irq_early", {7'b0, o_irq}, 8'h00);
    step(1);
    chk("press_irq", {7'b0, o_irq}, 8'h01);
    do_read("press_state", 2'd1, 8'h02);
    do_read("press_evt", 2'd2, 8'h02);

    do_write(2'd2, 8'h02);
    chk("w1c_irq", {7'b0, o_irq}, 8'h00);

    // Clear collides with a fresh press of button 1: set wins.
    i_btn = 5'h00;
    step(8);
    do_write(2'd2, 8'h1F);
    i_btn = 5'h02;
    step(5);
    i_addr = 2'd2; i_wr_data = 8'h02; i_wr_en = 1'b1;
    step(1);
    i_wr_en = 1'b0;
    chk("collide_irq", {7'b0, o_irq}, 8'h01);
    do_read("collide_evt", 2'd2, 8'h02);
    do_write(2'd2, 8'h02);

    // Bounce on button 2: never stable for D edges.
    for (int i = 0; i < 10; i++) begin
      i_btn = (i % 2 == 0) ? 5'h06 : 5'h02;
      step(2);
    end
    i_btn = 5'h02;
    step(8);
    do_read("bounce_state", 2'd1, 8'h02);
    do_read("bounce_evt", 2'd2, 8'h00);
    chk("bounce_irq", {7'b0, o_irq}, 8'h00);

    // LED register, read hold, read/write collision, read-only registers.
    do_write(2'd0, 8'hA5);
    chk("led_write", o_led, 8'hA5);
    do_read("led_read", 2'd0, 8'hA5);
    step(1);
    chk("rd_valid_pulse", {7'b0, o_rd_valid}, 8'h00);
    chk("rd_data_hold", o_rd_data, 8'hA5);
    i_addr = 2'd0; i_wr_data = 8'h5A; i_wr_en = 1'b1; i_rd_en = 1'b1;
    step(1);
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    chk("rw_pre_value", o_rd_data, 8'hA5);
    chk("rw_led_new", o_led, 8'h5A);
    do_write(2'd1, 8'hFF);
    do_write(2'd3, 8'h00);
    do_read("ro_state", 2'd1, 8'h02);
    do_read("ro_sw", 2'd3, 8'hFF);

    // Switches: visible to a read sampled on the third edge after the change.
    i_sw = 8'h3C;
    step(2);
    do_read("sw_3c", 2'd3, 8'h3C);
    i_sw = 8'hC3;
    step(1);
    do_read("sw_old", 2'd3, 8'h3C);
    do_read("sw_c3", 2'd3, 8'hC3);

    // Release of button 1: event only when release events are enabled.
    do_write(2'd2, 8'h1F);
    i_btn = 5'h00;
    step(5);
    chk("release_irq_early", {7'b0, o_irq}, 8'h00);
    step(1);
    chk("release_irq", {7'b0, o_irq}, {7'b0, RelEvt});
    do_read("release_evt", 2'd2, RelEvt ? 8'h02 : 8'h00);
    do_read("release_state", 2'd1, 8'h00);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
